// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel bus timer.
package timer_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_FREE    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Decoded per-channel register write strobes.
  typedef struct packed {
    logic status;
    logic count;
    logic preset;
    logic ctrl;
  } reg_we_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: ctrl/preset/count/pend state, counting rules and read-back words.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_we_t     we,
  input  logic [31:0] dat,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        irq
);

  logic             en;
  logic             im;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             pend;

  logic bus_wr;
  logic cnt_act;
  logic event_hit;

  // A STATUS write does not stall counting; only the registers that shape the count do.
  assign bus_wr    = we.ctrl | we.preset | we.count;
  assign cnt_act   = en & ~bus_wr & (mode != MODE_HOLD);
  assign event_hit = cnt_act & (count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en     <= 1'b0;
      im     <= 1'b0;
      mode   <= MODE_ONESHOT;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      if (we.ctrl) begin
        en   <= dat[CTRL_EN];
        mode <= dat[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= dat[CTRL_IM];
      end
      if (we.preset) preset <= CNT_W'(dat);
      if (we.count)  count  <= CNT_W'(dat);

      if (cnt_act) begin
        if (count != '0) begin
          count <= count - CNT_W'(1);
        end else begin
          case (mode)
            MODE_ONESHOT: en    <= 1'b0;
            MODE_RELOAD:  count <= preset;
            MODE_FREE:    count <= '1;
            default:      ;
          endcase
        end
      end

      // Event beats a same-cycle W1C so no interrupt is lost.
      if (event_hit)                 pend <= 1'b1;
      else if (we.status && dat[0])  pend <= 1'b0;
    end
  end

  assign ctrl_rd   = {28'd0, im, mode, en};
  assign preset_rd = 32'(preset);
  assign count_rd  = 32'(count);
  assign status_rd = {31'd0, pend};
  assign irq       = pend & im;

endmodule

// File: rtl/timer_multi.sv
// N_CH-channel down-counter timer behind one 32-bit word-addressed register port.
module timer_multi
  import timer_pkg::*;
#(
  parameter  int N_CH  = 2,
  parameter  int CNT_W = 32,
  localparam int AW    = $clog2(N_CH) + 2
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [AW+1:2]   ADDR_I,
  input  logic            WE_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            IRQ,
  output logic [N_CH-1:0] irq_vec
);

  localparam int CH_W = (AW > 2) ? AW - 2 : 1;

  logic [CH_W-1:0]             ch_idx;
  logic [1:0]                  reg_sel;
  logic                        ch_ok;
  logic [N_CH-1:0][3:0][31:0]  rd;

  assign reg_sel = ADDR_I[3:2];

  generate
    if (AW > 2) begin : g_idx
      assign ch_idx = ADDR_I[AW+1:4];
    end else begin : g_idx_single
      assign ch_idx = '0;
    end
  endgenerate

  // Channel indices past N_CH exist in the address space when N_CH is not a power of 2.
  assign ch_ok = int'(ch_idx) < N_CH;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic    hit;
      reg_we_t ch_we;

      assign hit          = WE_I & ch_ok & (ch_idx == CH_W'(i));
      assign ch_we.ctrl   = hit & (reg_sel == REG_CTRL);
      assign ch_we.preset = hit & (reg_sel == REG_PRESET);
      assign ch_we.count  = hit & (reg_sel == REG_COUNT);
      assign ch_we.status = hit & (reg_sel == REG_STATUS);

      timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk       (CLK_I),
        .rst       (RST_I),
        .we        (ch_we),
        .dat       (DAT_I),
        .ctrl_rd   (rd[i][REG_CTRL]),
        .preset_rd (rd[i][REG_PRESET]),
        .count_rd  (rd[i][REG_COUNT]),
        .status_rd (rd[i][REG_STATUS]),
        .irq       (irq_vec[i])
      );
    end
  endgenerate

  assign DAT_O = ch_ok ? rd[ch_idx][reg_sel] : 32'd0;
  assign IRQ   = |irq_vec;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi at N_CH=3 (one unused channel slot), CNT_W=8.
module tb_timer_multi;

  localparam int R_CTRL = 0, R_PRESET = 1, R_COUNT = 2, R_STATUS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [5:2]  addr = '0;
  logic [31:0] dat  = '0;
  logic [31:0] dat_o;
  logic        irq;
  logic [2:0]  irq_vec;

  int n_cmp = 0;
  int n_err = 0;

  timer_multi #(.N_CH(3), .CNT_W(8)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .ADDR_I  (addr),
    .WE_I    (we),
    .DAT_I   (dat),
    .DAT_O   (dat_o),
    .IRQ     (irq),
    .irq_vec (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input int ch, input int r, input logic [31:0] exp);
    addr = {2'(ch), 2'(r)};
    #1;
    chk(tag, dat_o, exp);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    addr = {2'(ch), 2'(r)};
    dat  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rl_seq [5];
    rl_seq = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd4};

    // Power-on reset
    tick(2);
    rdchk("por_ctrl0", 0, R_CTRL, 32'h0);
    chk("por_irq", irq, 1'b0);
    rst = 1'b0;
    tick(1);

    // Reset asserted mid-count
    wr(0, R_COUNT, 32'd50);
    wr(0, R_CTRL, 32'h1);
    tick(3);
    rdchk("pre_rst_count", 0, R_COUNT, 32'd47);
    rst = 1'b1;
    #1;
    rdchk("async_rst_count", 0, R_COUNT, 32'h0);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        rdchk($sformatf("rst_ch%0d_r%0d", c, r), c, r, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_irq_vec", irq_vec, 3'b000);
    rst = 1'b0;
    tick(2);
    rdchk("post_rst_idle", 0, R_COUNT, 32'h0);

    // One-shot on ch0
    wr(0, R_COUNT, 32'd3);
    wr(0, R_CTRL, 32'h9);
    tick(2);
    rdchk("os_count1", 0, R_COUNT, 32'd1);
    rdchk("os_pend_early", 0, R_STATUS, 32'h0);
    chk("os_irq_early", irq, 1'b0);
    tick(1);
    rdchk("os_count0", 0, R_COUNT, 32'd0);
    rdchk("os_pend", 0, R_STATUS, 32'h1);
    chk("os_irq", irq, 1'b1);
    rdchk("os_ctrl_still_en", 0, R_CTRL, 32'h9);
    tick(1);
    rdchk("os_ctrl_autoclr", 0, R_CTRL, 32'h8);
    rdchk("os_count_hold", 0, R_COUNT, 32'd0);
    wr(0, R_STATUS, 32'h0);
    rdchk("os_w0_noeffect", 0, R_STATUS, 32'h1);
    wr(0, R_STATUS, 32'h1);
    rdchk("os_w1c", 0, R_STATUS, 32'h0);
    chk("os_irq_drop", irq, 1'b0);

    // Auto-reload on ch1
    wr(1, R_PRESET, 32'd4);
    rdchk("rl_preset_noload", 1, R_COUNT, 32'd0);
    wr(1, R_COUNT, 32'd4);
    wr(1, R_CTRL, 32'hB);
    rdchk("rl_ctrl_wr_hold", 1, R_COUNT, 32'd4);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      rdchk($sformatf("rl_seq%0d", k), 1, R_COUNT, 32'(rl_seq[k]));
      if (k == 3) begin
        rdchk("rl_pend", 1, R_STATUS, 32'h1);
        chk("rl_irq_vec", irq_vec, 3'b010);
      end
    end
    tick(4);
    rdchk("rl_count_2nd", 1, R_COUNT, 32'd0);
    rdchk("rl_sticky", 1, R_STATUS, 32'h1);
    wr(1, R_STATUS, 32'h1);
    rdchk("rl_clr", 1, R_STATUS, 32'h0);
    rdchk("rl_reload", 1, R_COUNT, 32'd4);

    // Event and W1C on the same edge
    tick(3);
    wr(1, R_STATUS, 32'h1);
    rdchk("col_count", 1, R_COUNT, 32'd0);
    rdchk("col_set_wins", 1, R_STATUS, 32'h1);
    wr(1, R_STATUS, 32'h1);
    rdchk("col_clr", 1, R_STATUS, 32'h0);

    // Write to ch0 while ch1 counts; also width truncation
    wr(0, R_COUNT, 32'h1A5);
    rdchk("col_ch0_load", 0, R_COUNT, 32'hA5);
    rdchk("col_ch1_undisturbed", 1, R_COUNT, 32'd3);
    tick(2);
    rdchk("col_ch0_hold", 0, R_COUNT, 32'hA5);
    rdchk("col_ch1_cnt", 1, R_COUNT, 32'd1);
    tick(1);
    rdchk("im_pend", 1, R_STATUS, 32'h1);
    chk("im_irq_on", irq, 1'b1);
    wr(1, R_CTRL, 32'h3);
    chk("im_irq_off", irq, 1'b0);
    chk("im_irq_vec_off", irq_vec, 3'b000);
    rdchk("im_pend_kept", 1, R_STATUS, 32'h1);
    rdchk("im_ctrl", 1, R_CTRL, 32'h3);

    // Unused channel slot
    wr(3, R_COUNT, 32'h55);
    rdchk("oor_count", 3, R_COUNT, 32'h0);
    rdchk("oor_ctrl", 3, R_CTRL, 32'h0);
    rdchk("oor_no_alias", 0, R_COUNT, 32'hA5);

    // Free-run wrap on ch2, then hold
    wr(2, R_COUNT, 32'd1);
    wr(2, R_CTRL, 32'h5);
    tick(1);
    rdchk("fr_count0", 2, R_COUNT, 32'd0);
    rdchk("fr_pend", 2, R_STATUS, 32'h1);
    tick(1);
    rdchk("fr_wrap", 2, R_COUNT, 32'hFF);
    wr(2, R_STATUS, 32'h1);
    rdchk("fr_count_fe", 2, R_COUNT, 32'hFE);
    rdchk("fr_one_event", 2, R_STATUS, 32'h0);
    wr(2, R_CTRL, 32'h7);
    tick(2);
    rdchk("hold_frozen", 2, R_COUNT, 32'hFE);
    rdchk("hold_no_event", 2, R_STATUS, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
